hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard detector for the 5-stage PoliRISC-V core (IF/ID/EX/MEM/WB).
- Compares ID-stage source registers against EX/MEM destination registers and produces stall and flush controls.
- Raises flushes on control-flow changes and on a global flush request.
- Hazard logic is purely combinational. An optional clocked block adds performance counters.

Parameters:
- CNT_WIDTH, default 32: width of the optional performance counters.

Ports:
- clock  in  1  core clock; used only by the optional counters.
- reset_n  in  1  asynchronous, active-low reset.
- hazard_type  in  hazard_t  from hazard_unit_pkg: NoHazard, HazardDecode, HazardExecute.
- rs_used  in  rs_used_t (1 bit)  1 = rs2 is a real operand of the ID instruction.
- pc_src  in  pc_src_t  from branch_decoder_unit_pkg; PcPlus4 = sequential fetch.
- rs1_id  in  5  ID-stage source register 1.
- rs2_id  in  5  ID-stage source register 2.
- rd_ex  in  5  EX-stage destination register.
- rd_mem  in  5  MEM-stage destination register.
- reg_we_ex  in  1  EX instruction writes the register file.
- reg_we_mem  in  1  MEM instruction writes the register file.
- mem_rd_en_ex  in  1  EX instruction is a load.
- mem_rd_en_mem  in  1  MEM instruction is a load.
- store_id  in  1  ID instruction is a store (its rs2 is store data).
- rd_complete_ex  in  1  EX result is already available for forwarding.
- flush_all  in  1  global flush request (trap/exception).
- stall_if  out  1  hold PC / IF stage.
- stall_id  out  1  hold IF/ID register.
- flush_id  out  1  bubble the IF/ID register.
- flush_ex  out  1  bubble the ID/EX register.
- flush_mem  out  1  bubble the EX/MEM register.
- stall_count  out  CNT_WIDTH  optional; see Optional Feature.
- flush_count  out  CNT_WIDTH  optional; see Optional Feature.

Behaviour:
- All hazard outputs are combinational from the inputs, with zero latency. No reset dependence.
- Effective source operands:
  - s1 = rs1_id.
  - s2 = rs_used ? rs2_id : 5'd0.
- match(s, rd, we, en) = (s == rd) && (rd != 0) && we && en. Register x0 never causes a hazard.
- HazardDecode (operands consumed in ID): s is hazardous if either holds:
  - match(s, rd_ex, reg_we_ex, !rd_complete_ex)
  - match(s, rd_mem, reg_we_mem, mem_rd_en_mem)
- HazardExecute (operands consumed in EX):
  - s1 is hazardous if match(s1, rd_ex, reg_we_ex, mem_rd_en_ex).
  - s2 is hazardous if match(s2, rd_ex, reg_we_ex, mem_rd_en_ex && !store_id). Store data is forwarded later.
- NoHazard: never stalls.
- stall = hazard on s1 OR hazard on s2. When stall is set, stall_if = stall_id = flush_ex = 1.
- If flush_all = 1:
  - flush_id = flush_ex = flush_mem = 1.
  - stall_if and stall_id still follow the stall term.
- Else if pc_src != PcPlus4: flush_id = 1.
- Otherwise flush_id = 0, and flush_mem = 0.
- Simultaneous stall and redirect: both the stall outputs and flush_id are asserted.
- X-free: every output is driven for all legal enum values.

Optional Feature:
- Macro: HAZARD_UNIT_PERF_CNT_EN.
- With the macro defined:
  - stall_count and flush_count are added.
  - Both reset asynchronously to 0 when reset_n = 0.
  - On each rising clock edge, stall_count += 1 when stall_if = 1.
  - On each rising clock edge, flush_count += 1 when flush_id = 1.
  - Both counters saturate at all-ones; no wrap.
- Without the macro: the counters and their ports are absent. clock and reset_n remain as ports but are unused, and behaviour is purely combinational.

Test Plan:
- HazardDecode, rs1_id=5, rd_ex=5, reg_we_ex=1, rd_complete_ex=0, pc_src=PcPlus4 -> stall_if=stall_id=flush_ex=1, flush_id=flush_mem=0. With rd_complete_ex=1 -> all outputs 0.
- HazardExecute, rs2_id=7, rs_used=1, rd_ex=7, reg_we_ex=1, mem_rd_en_ex=1, store_id=1 -> no stall. With store_id=0 -> stall_if=stall_id=flush_ex=1. With rs_used=0 -> no stall.
- HazardDecode, rs1_id=0, rd_ex=0, reg_we_ex=1, rd_complete_ex=0 -> no stall (x0 exemption).
- HazardDecode, rs1_id=9, rd_mem=9, reg_we_mem=1, mem_rd_en_mem=1 -> stall. With mem_rd_en_mem=0 -> no stall.
- pc_src != PcPlus4, no hazard -> only flush_id=1. Then flush_all=1 -> flush_id=flush_ex=flush_mem=1, with stall outputs unchanged.
- HAZARD_UNIT_PERF_CNT_EN: hold reset_n=0 -> counters 0. Release reset_n, then 3 cycles with a stall -> stall_count=3. Preload near all-ones -> counters saturate.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard detector: combinational stall/flush controls for the 5-stage core.
// Optional saturating stall/flush performance counters when HAZARD_UNIT_PERF_CNT_EN is defined.
package hazard_unit_pkg;
    typedef enum logic [1:0] {
        NoHazard      = 2'd0,
        HazardDecode  = 2'd1,
        HazardExecute = 2'd2
    } hazard_t;

    typedef logic rs_used_t;
endpackage

package branch_decoder_unit_pkg;
    typedef enum logic [1:0] {
        PcPlus4  = 2'd0,
        PcBranch = 2'd1,
        PcJalr   = 2'd2,
        PcTrap   = 2'd3
    } pc_src_t;
endpackage

module hazard_unit
    import hazard_unit_pkg::*;
    import branch_decoder_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  hazard_t              hazard_type,
    input  rs_used_t             rs_used,
    input  pc_src_t              pc_src,
    input  logic [4:0]           rs1_id,
    input  logic [4:0]           rs2_id,
    input  logic [4:0]           rd_ex,
    input  logic [4:0]           rd_mem,
    input  logic                 reg_we_ex,
    input  logic                 reg_we_mem,
    input  logic                 mem_rd_en_ex,
    input  logic                 mem_rd_en_mem,
    input  logic                 store_id,
    input  logic                 rd_complete_ex,
    input  logic                 flush_all,
`ifdef HAZARD_UNIT_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count,
`endif
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic                 flush_mem
);

    logic [4:0] s1;
    logic [4:0] s2;
    logic       haz_s1;
    logic       haz_s2;
    logic       stall;

    function automatic logic match(input logic [4:0] s, input logic [4:0] rd,
                                   input logic we, input logic en);
        return (s == rd) && (rd != 5'd0) && we && en;
    endfunction

    assign s1 = rs1_id;
    assign s2 = rs_used ? rs2_id : 5'd0;

    always_comb begin
        haz_s1 = 1'b0;
        haz_s2 = 1'b0;
        case (hazard_type)
            HazardDecode: begin
                haz_s1 = match(s1, rd_ex, reg_we_ex, !rd_complete_ex)
                       || match(s1, rd_mem, reg_we_mem, mem_rd_en_mem);
                haz_s2 = match(s2, rd_ex, reg_we_ex, !rd_complete_ex)
                       || match(s2, rd_mem, reg_we_mem, mem_rd_en_mem);
            end
            HazardExecute: begin
                // Store data is forwarded in MEM, so a store's rs2 never waits on a load.
                haz_s1 = match(s1, rd_ex, reg_we_ex, mem_rd_en_ex);
                haz_s2 = match(s2, rd_ex, reg_we_ex, mem_rd_en_ex && !store_id);
            end
            default: begin
                haz_s1 = 1'b0;
                haz_s2 = 1'b0;
            end
        endcase
    end

    assign stall = haz_s1 || haz_s2;

    always_comb begin
        stall_if  = stall;
        stall_id  = stall;
        flush_ex  = stall || flush_all;
        flush_mem = flush_all;
        flush_id  = flush_all || (pc_src != PcPlus4);
    end

`ifdef HAZARD_UNIT_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_if && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (flush_id && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clock, reset_n, CNT_WIDTH[0]};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; counter checks run only with HAZARD_UNIT_PERF_CNT_EN.
module tb_hazard_unit;
    import hazard_unit_pkg::*;
    import branch_decoder_unit_pkg::*;

    localparam int CW = 3;

    logic       clock;
    logic       reset_n;
    hazard_t    hazard_type;
    rs_used_t   rs_used;
    pc_src_t    pc_src;
    logic [4:0] rs1_id, rs2_id, rd_ex, rd_mem;
    logic       reg_we_ex, reg_we_mem, mem_rd_en_ex, mem_rd_en_mem;
    logic       store_id, rd_complete_ex, flush_all;
    logic       stall_if, stall_id, flush_id, flush_ex, flush_mem;
`ifdef HAZARD_UNIT_PERF_CNT_EN
    logic [CW-1:0] stall_count, flush_count;
`endif

    int passed = 0;
    int total  = 0;

    hazard_unit #(.CNT_WIDTH(CW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .hazard_type    (hazard_type),
        .rs_used        (rs_used),
        .pc_src         (pc_src),
        .rs1_id         (rs1_id),
        .rs2_id         (rs2_id),
        .rd_ex          (rd_ex),
        .rd_mem         (rd_mem),
        .reg_we_ex      (reg_we_ex),
        .reg_we_mem     (reg_we_mem),
        .mem_rd_en_ex   (mem_rd_en_ex),
        .mem_rd_en_mem  (mem_rd_en_mem),
        .store_id       (store_id),
        .rd_complete_ex (rd_complete_ex),
        .flush_all      (flush_all),
`ifdef HAZARD_UNIT_PERF_CNT_EN
        .stall_count    (stall_count),
        .flush_count    (flush_count),
`endif
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .flush_id       (flush_id),
        .flush_ex       (flush_ex),
        .flush_mem      (flush_mem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output vector order: {stall_if, stall_id, flush_id, flush_ex, flush_mem}
    localparam logic [4:0] NONE     = 5'b00000;
    localparam logic [4:0] STALL    = 5'b11010;
    localparam logic [4:0] REDIR    = 5'b00100;
    localparam logic [4:0] FALL     = 5'b00111;
    localparam logic [4:0] STALL_RD = 5'b11110;
    localparam logic [4:0] STALL_FA = 5'b11111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, {27'd0, stall_if, stall_id, flush_id, flush_ex, flush_mem}, {27'd0, exp});
    endtask

    task automatic idle();
        hazard_type    = NoHazard;
        rs_used        = 1'b0;
        pc_src         = PcPlus4;
        rs1_id         = 5'd0;
        rs2_id         = 5'd0;
        rd_ex          = 5'd0;
        rd_mem         = 5'd0;
        reg_we_ex      = 1'b0;
        reg_we_mem     = 1'b0;
        mem_rd_en_ex   = 1'b0;
        mem_rd_en_mem  = 1'b0;
        store_id       = 1'b0;
        rd_complete_ex = 1'b0;
        flush_all      = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        chk_out("idle_all_zero", NONE);

        // Decode hazard against EX result not yet available
        hazard_type = HazardDecode; rs1_id = 5'd5; rd_ex = 5'd5; reg_we_ex = 1'b1;
        chk_out("dec_ex_rs1_stall", STALL);
        rd_complete_ex = 1'b1;
        chk_out("dec_ex_complete", NONE);
        rd_complete_ex = 1'b0; reg_we_ex = 1'b0;
        chk_out("dec_ex_no_we", NONE);

        // Decode rs2 only counts when rs_used
        idle(); hazard_type = HazardDecode; rs1_id = 5'd3; rs2_id = 5'd12;
        rd_ex = 5'd12; reg_we_ex = 1'b1;
        chk_out("dec_rs2_unused", NONE);
        rs_used = 1'b1;
        chk_out("dec_rs2_used", STALL);

        // Execute hazard: load-use on rs2, store data exempt
        idle(); hazard_type = HazardExecute; rs2_id = 5'd7; rs_used = 1'b1;
        rd_ex = 5'd7; reg_we_ex = 1'b1; mem_rd_en_ex = 1'b1; store_id = 1'b1;
        chk_out("exe_store_rs2", NONE);
        store_id = 1'b0;
        chk_out("exe_load_rs2", STALL);
        rs_used = 1'b0;
        chk_out("exe_rs2_unused", NONE);

        // Execute rs1 load-use stalls even for stores; needs the EX load
        idle(); hazard_type = HazardExecute; rs1_id = 5'd4; store_id = 1'b1;
        rd_ex = 5'd4; reg_we_ex = 1'b1; mem_rd_en_ex = 1'b1;
        chk_out("exe_rs1_store", STALL);
        mem_rd_en_ex = 1'b0;
        chk_out("exe_rs1_no_load", NONE);

        // x0 exemption
        idle(); hazard_type = HazardDecode; reg_we_ex = 1'b1;
        chk_out("dec_x0", NONE);

        // Decode hazard against MEM load
        idle(); hazard_type = HazardDecode; rs1_id = 5'd9; rd_mem = 5'd9;
        reg_we_mem = 1'b1; mem_rd_en_mem = 1'b1;
        chk_out("dec_mem_load", STALL);
        hazard_type = HazardExecute;
        chk_out("exe_ignores_mem", NONE);
        hazard_type = HazardDecode; mem_rd_en_mem = 1'b0;
        chk_out("dec_mem_no_load", NONE);

        // NoHazard never stalls
        idle(); rs1_id = 5'd6; rd_ex = 5'd6; reg_we_ex = 1'b1; mem_rd_en_ex = 1'b1;
        chk_out("nohazard", NONE);

        // Redirects and global flush
        idle(); pc_src = PcBranch;
        chk_out("redirect", REDIR);
        flush_all = 1'b1;
        chk_out("flush_all", FALL);
        pc_src = PcPlus4;
        chk_out("flush_all_seq", FALL);
        hazard_type = HazardDecode; rs1_id = 5'd5; rd_ex = 5'd5; reg_we_ex = 1'b1;
        chk_out("stall_flush_all", STALL_FA);
        flush_all = 1'b0; pc_src = PcJalr;
        chk_out("stall_redirect", STALL_RD);

`ifdef HAZARD_UNIT_PERF_CNT_EN
        idle();
        @(negedge clock);
        chk("cnt_reset_stall", {29'd0, stall_count}, 32'd0);
        chk("cnt_reset_flush", {29'd0, flush_count}, 32'd0);
        reset_n = 1'b1;
        hazard_type = HazardDecode; rs1_id = 5'd5; rd_ex = 5'd5; reg_we_ex = 1'b1;
        repeat (3) @(negedge clock);
        idle();
        chk("cnt_stall3", {29'd0, stall_count}, 32'd3);
        chk("cnt_flush0", {29'd0, flush_count}, 32'd0);
        hazard_type = HazardDecode; rs1_id = 5'd5; rd_ex = 5'd5; reg_we_ex = 1'b1;
        pc_src = PcTrap;
        repeat (10) @(negedge clock);
        idle();
        chk("cnt_stall_sat", {29'd0, stall_count}, 32'd7);
        chk("cnt_flush_sat", {29'd0, flush_count}, 32'd7);
        reset_n = 1'b0;
        #1;
        chk("cnt_async_reset", {26'd0, stall_count, flush_count}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
